display_scan: RTL and testbench
===============================

# display_scan

Multiplexed seven-segment scan driver that sits directly upstream of the `display7` decoder. It holds a multi-digit value, time-multiplexes one 4-bit digit at a time onto the decoder's `iData` input, and drives the matching active-low anode select. New values are applied only at frame boundaries, so a frame never shows digits from two different values. Optional leading-zero blanking is provided.

## Interface
- `DIGITS`, default 8: number of digits scanned, 2..8.
- `DIV`, default 100000: clock cycles each digit stays lit. Minimum 2.
- `iClk`  in  1: clock; all state updates on the rising edge.
- `iRst`  in  1: synchronous, active-high reset.
- `iLoad`  in  1: single-cycle request to capture `iValue`.
- `iValue`  in  4*DIGITS: new display value. Digit k is `iValue[4k+3:4k]`; digit 0 is the rightmost.
- `iBlankLZ`  in  1: leading-zero blanking enable. Sampled every cycle.
- `oDigit`  out  4: current digit code, wired to `display7.iData`.
- `oAnode`  out  DIGITS: active-low digit select. At most one bit is low.
- `oFrame`  out  1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` = (`cnt`==DIV-1).
- Digit index `idx` counts 0..DIGITS-1. It advances on `tick` and wraps from DIGITS-1 to 0.
- Frame boundary: `tick` && `idx`==DIGITS-1.
- Display register `disp`, width 4*DIGITS. Pending register `pend` with flag `pvalid`.
- Load when `iLoad`=1 and the cycle is not a frame boundary:
  - `pend`<=`iValue`, `pvalid`<=1.
  - A later `iLoad` before the next boundary overwrites `pend`; the last value wins.
- Frame boundary cycle:
  - If `iLoad`=1: `disp`<=`iValue` (bypass), `pvalid`<=0.
  - Else if `pvalid`=1: `disp`<=`pend`, `pvalid`<=0.
  - Else: `disp` is unchanged.
- `oDigit` = `disp[4*idx+3:4*idx]`.
- Blanking for digit `idx` applies when all of the following hold:
  - `iBlankLZ`=1,
  - `idx`!=0,
  - every digit from `idx` up to DIGITS-1 of `disp` is 0.
- `oAnode`:
  - Not blanked: all ones except bit `idx`=0.
  - Blanked: all ones. `oDigit` still carries 0.
- Digit codes 10..15 pass through unmodified. Their interpretation is the decoder's concern.
- `oFrame` is registered. It is 1 in the cycle after a frame-boundary cycle, i.e. the first cycle with `idx`=0.

## Timing
- Reset values, one cycle after `iRst` is sampled high:
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pvalid`=0, `oFrame`=0.
  - Hence `oDigit`=0 and `oAnode`=~1 (only digit 0 lit).
- `iRst` has priority over `iLoad` and `tick`. Asserting it mid-frame or mid-load discards the pending value and restarts the scan at digit 0 on the next edge.
- `oDigit` and `oAnode` are combinational decodes of registered state only. There is no combinational path from any input except `iBlankLZ` to `oAnode`.
- Each digit is lit for exactly DIV cycles. A full frame is DIGITS*DIV cycles.
- Load latency:
  - The new value appears on `oDigit` in the first cycle of the next frame, the same cycle `oFrame`=1.
  - Worst case DIGITS*DIV cycles after `iLoad`; best case 1 cycle when `iLoad` lands on the boundary cycle.
- `iLoad` held high for several cycles behaves as repeated loads. The last sampled value wins.

## Test plan
- Reset and scan: DIGITS=8, DIV=4, `iRst` 2 cycles then released. Check reset: `oAnode`=8'hFE and `oDigit`=0. After release, `oAnode` steps FE, FD, FB, ... 7F, FE, each for 4 cycles. `oFrame` pulses once every 32 cycles, coincident with the return to FE.
- Deferred load: DIV=4, `iLoad` with `iValue`=32'h87654321 at cycle 5 (mid-frame). `oDigit` stays 0 until the next `oFrame`. Then `oDigit` reads 1,2,3,...,8 across the frame.
- Boundary bypass and overwrite:
  - Load 32'h11111111 mid-frame, then 32'h22222222 on the exact boundary cycle. The next frame shows all 2s.
  - Two mid-frame loads (A then B) → the next frame shows B only.
- Leading-zero blanking: `disp`=32'h00000305, `iBlankLZ`=1.
  - Digits 0..2 lit with codes 5, 0, 3.
  - Digits 3..7 have `oAnode`=all ones.
  - `disp`=0 → only digit 0 lit, showing 0.
  - `iBlankLZ`=0 → all 8 digits lit.
- Reset mid-operation: pending load outstanding and `idx`=5. Assert `iRst` for 1 cycle. Next cycle: `idx`=0, `oAnode`=FE, `oDigit`=0, `oFrame`=0. The pending value is never displayed.
- Pass-through of non-BCD codes: `iValue`=32'hFEDCBA98. `oDigit` reads 8,9,A,B,C,D,E,F in scan order.

Source files
------------

// File: rtl/display_scan.sv
// rtl/display_scan.sv - multiplexed seven-segment scan driver with frame-aligned loads
// Feeds one digit per DIV cycles to the display7 decoder; new values take effect only at frame wrap.
module display_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iValue,
    input  logic                  iBlankLZ,
    output logic [3:0]            oDigit,
    output logic [DIGITS-1:0]     oAnode,
    output logic                  oFrame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pvalid_q, pvalid_d;
    logic                  frame_q, frame_d;

    logic                  tick;
    logic                  boundary;
    logic [4*DIGITS-1:0]   upper;
    logic                  blank;

    assign tick     = (cnt_q == CW'(DIV - 1));
    assign boundary = tick && (idx_q == IW'(DIGITS - 1));

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        pvalid_d = pvalid_q;
        frame_d  = boundary;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        // A load on the boundary itself bypasses the pending register.
        if (boundary) begin
            if (iLoad) begin
                disp_d = iValue;
            end else if (pvalid_q) begin
                disp_d = pend_q;
            end
            pvalid_d = 1'b0;
        end else if (iLoad) begin
            pend_d   = iValue;
            pvalid_d = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pvalid_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pvalid_q <= pvalid_d;
            frame_q  <= frame_d;
        end
    end

    // Digits at and above idx all zero means this digit is a leading zero.
    assign upper  = disp_q >> {idx_q, 2'b00};
    assign blank  = iBlankLZ && (idx_q != '0) && (upper == '0);
    assign oDigit = disp_q[{idx_q, 2'b00} +: 4];
    assign oAnode = blank ? '1 : ~(DIGITS'(1) << idx_q);
    assign oFrame = frame_q;
endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized and directed bench for display_scan against a time-based model
module tb_display_scan;
    localparam int D  = 8;
    localparam int V  = 4;
    localparam int DV = D * V;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iLoad = 1'b0;
    logic [31:0]   iValue = '0;
    logic          iBlankLZ = 1'b0;
    logic [3:0]    oDigit;
    logic [7:0]    oAnode;
    logic          oFrame;

    int n_checks = 0;
    int n_fail   = 0;

    int          t;
    logic [31:0] m_disp, m_pend;
    logic        m_pvalid, m_frame;

    display_scan #(.DIGITS(D), .DIV(V)) dut (
        .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iValue(iValue),
        .iBlankLZ(iBlankLZ), .oDigit(oDigit), .oAnode(oAnode), .oFrame(oFrame)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0d", tag, obs, exp, t);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic step();
        int          idx;
        logic [31:0] upper;
        logic        blank;
        logic [7:0]  ea;
        logic        bnd;
        @(posedge iClk);
        if (iRst) begin
            t = 0; m_disp = '0; m_pend = '0; m_pvalid = 1'b0; m_frame = 1'b0;
        end else begin
            bnd = ((t % DV) == DV - 1);
            if (bnd) begin
                if (iLoad) m_disp = iValue;
                else if (m_pvalid) m_disp = m_pend;
                m_pvalid = 1'b0;
            end else if (iLoad) begin
                m_pend = iValue;
                m_pvalid = 1'b1;
            end
            m_frame = bnd;
            t++;
        end
        #1;
        idx   = (t / V) % D;
        upper = m_disp >> (4 * idx);
        blank = iBlankLZ && (idx != 0) && (upper == 0);
        ea    = 8'hFF;
        if (!blank) ea[idx] = 1'b0;
        check("digit", {28'd0, oDigit}, upper & 32'hF);
        check("anode", {24'd0, oAnode}, {24'd0, ea});
        check("frame", {31'd0, oFrame}, {31'd0, m_frame});
    endtask

    task automatic load_cycle(input logic [31:0] v);
        iLoad = 1'b1; iValue = v;
        step();
        iLoad = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_frame();
        int n = 0;
        while ((t % DV) != 0 && n < 2 * DV) begin step(); n++; end
    endtask

    initial begin
        int lit;
        logic [31:0] b_val, v;
        t = 0; m_disp = '0; m_pend = '0; m_pvalid = 1'b0; m_frame = 1'b0;

        // Reset and scan order
        iRst = 1'b1;
        run(2);
        check("rst_anode", {24'd0, oAnode}, 32'hFE);
        check("rst_digit", {28'd0, oDigit}, 32'h0);
        check("rst_frame", {31'd0, oFrame}, 32'h0);
        iRst = 1'b0;
        for (int i = 0; i < 2 * DV; i++) begin
            check("scan_anode", {24'd0, oAnode}, {24'd0, ~(8'h01 << ((i / V) % D))});
            check("scan_frame", {31'd0, oFrame}, (i > 0 && (i % DV) == 0) ? 32'h1 : 32'h0);
            step();
        end

        // Deferred load at cycle 5 of a frame
        run(5);
        load_cycle(32'h87654321);
        while ((t % DV) != 0) begin
            check("defer_hold", {28'd0, oDigit}, 32'h0);
            step();
        end
        check("defer_frame", {31'd0, oFrame}, 32'h1);
        for (int k = 0; k < D; k++)
            for (int j = 0; j < V; j++) begin
                check("defer_seq", {28'd0, oDigit}, k + 1);
                step();
            end

        // Mid-frame load overridden by a load on the boundary cycle
        run(3);
        load_cycle(32'h11111111);
        while ((t % DV) != DV - 1) step();
        load_cycle(32'h22222222);
        check("bypass_frame", {31'd0, oFrame}, 32'h1);
        for (int i = 0; i < DV; i++) begin
            check("bypass", {28'd0, oDigit}, 32'h2);
            step();
        end

        // Two mid-frame loads: last one wins
        run(2);
        load_cycle(32'hA5A5A5A5);
        run(3);
        b_val = 32'hB0C1D2E3;
        load_cycle(b_val);
        wait_frame();
        for (int i = 0; i < DV; i++) begin
            check("overwrite", {28'd0, oDigit}, (b_val >> (4 * ((i / V) % D))) & 32'hF);
            step();
        end

        // Leading-zero blanking
        run(1);
        load_cycle(32'h00000305);
        wait_frame();
        iBlankLZ = 1'b1;
        lit = 0;
        for (int i = 0; i < DV; i++) begin
            if (oAnode != 8'hFF) lit++;
            step();
        end
        check("blank_lit_305", lit, 12);
        load_cycle(32'h0);
        wait_frame();
        lit = 0;
        for (int i = 0; i < DV; i++) begin
            if (oAnode != 8'hFF) lit++;
            step();
        end
        check("blank_lit_zero", lit, 4);
        iBlankLZ = 1'b0;
        lit = 0;
        for (int i = 0; i < DV; i++) begin
            if (oAnode != 8'hFF) lit++;
            step();
        end
        check("noblank_lit", lit, DV);

        // Reset mid-frame with a pending load outstanding
        run(2);
        load_cycle(32'h99999999);
        while (((t / V) % D) != 5) step();
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        check("rstmid_anode", {24'd0, oAnode}, 32'hFE);
        check("rstmid_digit", {28'd0, oDigit}, 32'h0);
        check("rstmid_frame", {31'd0, oFrame}, 32'h0);
        for (int i = 0; i < DV + 8; i++) begin
            check("rst_discard", {28'd0, oDigit}, 32'h0);
            step();
        end

        // Non-BCD codes pass through
        load_cycle(32'hFEDCBA98);
        wait_frame();
        for (int k = 0; k < D; k++)
            for (int j = 0; j < V; j++) begin
                check("nonbcd", {28'd0, oDigit}, k + 8);
                step();
            end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            v = $urandom;
            for (int k = 0; k < D; k++)
                if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
            iValue = v;
            iLoad  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) iBlankLZ = $urandom_range(0, 1) == 1;
            iRst   = ($urandom_range(0, 199) == 0);
            step();
        end
        iLoad = 1'b0;
        iRst  = 1'b0;
        run(DV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
